// File: rtl/csea_16.sv
// csea_16 -- 16-bit carry-skip adder with registered result.
//
// The operands are split into four 4-bit ripple blocks. Each block forwards
// its carry-in straight to its carry-out when all four bits propagate, so the
// longest carry chain becomes: ripple block 0, skip blocks 1-2, ripple block 3.
// {Cout, Sum} is bit-exact with A + B + Cin and is captured every rising edge.
//
// Configuration macro:
//   CSEA16_IN_REG_EN  defined   -> A, B, Cin are registered before the adder
//                                  (latency 2 cycles)
//                     undefined -> inputs feed the adder directly (latency 1)
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset, clears all registers
//   A      in  16   operand A, unsigned
//   B      in  16   operand B, unsigned
//   Cin    in   1   carry into bit 0
//   Sum    out 16   registered (A + B + Cin)[15:0]
//   Cout   out  1   registered carry out of bit 15

module csea_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  localparam int BLK_W = 4;
  localparam int N_BLK = 4;

  // 4-bit ripple block with skip mux. Returns {carry_out, sum[3:0]}.
  function automatic logic [BLK_W:0] skip_block(
    input logic [BLK_W-1:0] a,
    input logic [BLK_W-1:0] b,
    input logic             ci
  );
    logic [BLK_W-1:0] p;
    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] s;
    logic             rc;
    p  = a ^ b;
    g  = a & b;
    s  = '0;
    rc = ci;
    for (int j = 0; j < BLK_W; j++) begin
      s[j] = p[j] ^ rc;
      rc   = g[j] | (p[j] & rc);
    end
    // When every bit propagates, the ripple result equals ci anyway; the
    // mux exists so the timing path from ci bypasses the ripple chain.
    skip_block = {((&p) ? ci : rc), s};
  endfunction

  logic [15:0] a_p0;
  logic [15:0] b_p0;
  logic        cin_p0;

  // ---- stage 0: adder operands (optionally registered) ----
`ifdef CSEA16_IN_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      a_p0   <= A;
      b_p0   <= B;
      cin_p0 <= Cin;
    end
  end
`else
  assign a_p0   = A;
  assign b_p0   = B;
  assign cin_p0 = Cin;
`endif

  logic [N_BLK:0]   bc;    // inter-block carries; bc[0] is Cin
  logic [15:0]      s_p0;
  logic [BLK_W:0]   blk_res;

  always_comb begin
    bc      = '0;
    s_p0    = '0;
    blk_res = '0;
    bc[0]   = cin_p0;
    for (int k = 0; k < N_BLK; k++) begin
      blk_res               = skip_block(a_p0[BLK_W*k +: BLK_W],
                                         b_p0[BLK_W*k +: BLK_W], bc[k]);
      s_p0[BLK_W*k +: BLK_W] = blk_res[BLK_W-1:0];
      bc[k+1]               = blk_res[BLK_W];
    end
  end

  logic [15:0] sum_p1;
  logic        cout_p1;

  // ---- stage 1: registered result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      sum_p1  <= s_p0;
      cout_p1 <= bc[N_BLK];
    end
  end

  assign Sum  = sum_p1;
  assign Cout = cout_p1;

endmodule

// File: tb/tb_csea_16.sv
// Self-checking bench for csea_16. Expected results come from a plain 17-bit
// addition held in a queue whose depth equals the build's latency.
`timescale 1ns/1ps
module tb_csea_16;

`ifdef CSEA16_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] Sum;
  logic        Cout;

  int errors;
  int checks;
  logic [16:0] expq[$];

  csea_16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] exp_v);
    checks++;
    assert ({Cout, Sum} === exp_v) else begin
      errors++;
      $error("FAIL %s: observed Cout=%0b Sum=%h expected Cout=%0b Sum=%h",
             tag, Cout, Sum, exp_v[16], exp_v[15:0]);
    end
  endtask

  // Apply one vector just after an edge, clock it, then compare once the
  // model queue holds LAT entries (the oldest is what should be visible).
  task automatic step(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic ci);
    logic [16:0] ref_v;
    A   = a;
    B   = b;
    Cin = ci;
    ref_v = {1'b0, a} + {1'b0, b} + {16'b0, ci};
    expq.push_back(ref_v);
    @(posedge clk);
    #1;
    if (expq.size() == LAT) chk(tag, expq.pop_front());
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    A      = 16'hFFFF;
    B      = 16'hFFFF;
    Cin    = 1'b1;

    // Reset held with all-ones inputs and clock running.
    #1;
    chk("reset_async", 17'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_held", 17'h0);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // That edge loaded the all-ones vector through the whole pipeline only
    // when there is no input stage; restart the model cleanly.
    expq.delete();

    // Directed vectors, back to back.
    step("zero",     16'h0000, 16'h0000, 1'b0);
    step("skip",     16'hFFFF, 16'h0001, 1'b0);
    step("mixed",    16'h1234, 16'h5678, 1'b1);
    step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    step("blk_prop", 16'h0F0F, 16'hF0F0, 1'b1);
    step("blk_gen",  16'h8888, 16'h8888, 1'b0);
    // Drain the remaining in-flight vectors.
    for (int i = 1; i < LAT; i++) step("drain", 16'h0000, 16'h0000, 1'b0);

    // Random vectors; some force full-propagate blocks to exercise the skips.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (($urandom_range(0, 3)) == 0) ? ~ra : 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      step("random", ra, rb, rc);

      if (i == 5000) begin
        // Mid-stream reset between edges: outputs clear with no clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid", 17'h0);
        @(posedge clk);
        #1;
        chk("reset_mid_held", 17'h0);
        #2;
        rst_n = 1'b1;
        expq.delete();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
